viterbi_decoder_param: RTL and testbench

VITERBI_DECODER_PARAM -- requirements
Module: viterbi_decoder_param

---
 rtl/viterbi_pkg.sv | 26 ++
 rtl/viterbi_acs_cell.sv | 76 +++++++
 rtl/viterbi_decoder_param.sv | 252 +++++++++++++++++++++++++
 tb/tb_viterbi_decoder_param.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/viterbi_pkg.sv
// Shared types and helpers for the parameterised Viterbi decoder.
package viterbi_pkg;

    // Frame-level control states of the decoder.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } vit_state_t;

    // Even parity (XOR reduction) of a tap-masked register.
    function automatic logic parity_f(input logic [31:0] vec);
        return ^vec;
    endfunction

    // Branch metric width: two distances of at most 2^SOFT_W-1 each.
    function automatic int bm_width_f(input int soft_w);
        return soft_w + 32'sd1;
    endfunction

    // Path metric width, with headroom over the normalised metric spread.
    function automatic int pm_width_f(input int soft_w, input int k);
        return soft_w + 32'sd1 + $clog2(k) + 32'sd1;
    endfunction

endpackage

// File: rtl/viterbi_acs_cell.sv
// Add-compare-select for one trellis state plus its register-exchange
// survivor update. Purely combinational; the top owns the registers.
module viterbi_acs_cell
    import viterbi_pkg::*;
#(
    parameter int           K        = 3,
    parameter logic [K-1:0] G0       = 3'b111,
    parameter logic [K-1:0] G1       = 3'b101,
    parameter int           SOFT_W   = 1,
    parameter int           TB_DEPTH = 15,
    parameter int           PM_W     = 5,
    parameter int           STATE    = 0
) (
    input  logic [SOFT_W-1:0]   rx0,
    input  logic [SOFT_W-1:0]   rx1,
    input  logic [PM_W-1:0]     pm_a,
    input  logic [PM_W-1:0]     pm_b,
    input  logic [TB_DEPTH-1:0] path_a,
    input  logic [TB_DEPTH-1:0] path_b,
    output logic [PM_W:0]       pm_new,
    output logic [TB_DEPTH-1:0] path_new
);

    localparam int NS     = 32'd1 << (K - 1);
    localparam int BM_W   = bm_width_f(SOFT_W);
    localparam int PRED_A = (STATE * 2) % NS;
    localparam int PRED_B = PRED_A + 1;

    localparam logic [K-2:0] ST_V = (K-1)'(STATE);
    localparam logic [K-2:0] PA_V = (K-1)'(PRED_A);
    localparam logic [K-2:0] PB_V = (K-1)'(PRED_B);
    // Input bit that drives any transition into this state.
    localparam logic         U_V  = ST_V[K-2];

    localparam logic [K-1:0] BR_A = {U_V, PA_V};
    localparam logic [K-1:0] BR_B = {U_V, PB_V};

    // Expected coded bits on each of the two incoming branches.
    localparam logic EA0 = parity_f(32'(G0 & BR_A));
    localparam logic EA1 = parity_f(32'(G1 & BR_A));
    localparam logic EB0 = parity_f(32'(G0 & BR_B));
    localparam logic EB1 = parity_f(32'(G1 & BR_B));

    localparam logic [SOFT_W-1:0] MAXV = {SOFT_W{1'b1}};

    logic [BM_W-1:0] bm_a_s;
    logic [BM_W-1:0] bm_b_s;
    logic [PM_W:0]   cand_a_s;
    logic [PM_W:0]   cand_b_s;

    // Distance from a received sample to the ideal level of an expected bit.
    function automatic logic [BM_W-1:0] dist_f(input logic [SOFT_W-1:0] rx,
                                               input logic exp_bit);
        if (exp_bit) begin
            return {1'b0, MAXV - rx};
        end else begin
            return {1'b0, rx};
        end
    endfunction

    // Branch metrics, candidate sums and the survivor decision (ties to pred A).
    always_comb begin
        bm_a_s   = dist_f(rx0, EA0) + dist_f(rx1, EA1);
        bm_b_s   = dist_f(rx0, EB0) + dist_f(rx1, EB1);
        cand_a_s = {1'b0, pm_a} + {{(PM_W-SOFT_W){1'b0}}, bm_a_s};
        cand_b_s = {1'b0, pm_b} + {{(PM_W-SOFT_W){1'b0}}, bm_b_s};
        if (cand_b_s < cand_a_s) begin
            pm_new   = cand_b_s;
            path_new = {path_b[TB_DEPTH-2:0], U_V};
        end else begin
            pm_new   = cand_a_s;
            path_new = {path_a[TB_DEPTH-2:0], U_V};
        end
    end

endmodule

// File: rtl/viterbi_decoder_param.sv
// Parameterised rate-1/2 Viterbi decoder with register-exchange survivors,
// framed input (i_first / i_last) and zero-tail drain of state 0's path.
module viterbi_decoder_param
    import viterbi_pkg::*;
#(
    parameter int           K        = 3,
    parameter logic [K-1:0] G0       = 3'b111,
    parameter logic [K-1:0] G1       = 3'b101,
    parameter int           SOFT_W   = 1,
    parameter int           TB_DEPTH = 15
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [SOFT_W-1:0] i_sym0,
    input  logic [SOFT_W-1:0] i_sym1,
    input  logic              i_first,
    input  logic              i_last,
    output logic              o_valid,
    output logic              o_bit,
    output logic              o_last
);

    localparam int NS    = 32'd1 << (K - 1);
    localparam int PM_W  = pm_width_f(SOFT_W, K);
    localparam int CNT_W = $clog2(TB_DEPTH + 1);

    localparam logic [PM_W-1:0]  PM_MAX   = {PM_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(TB_DEPTH);

    vit_state_t state_r;
    vit_state_t state_nx_s;

    logic [PM_W-1:0]     pm_r       [NS];
    logic [TB_DEPTH-1:0] path_r     [NS];
    logic [PM_W-1:0]     pm_src_s   [NS];
    logic [TB_DEPTH-1:0] path_src_s [NS];
    logic [PM_W:0]       acs_pm_s   [NS];
    logic [TB_DEPTH-1:0] acs_path_s [NS];
    logic [PM_W:0]       norm_s     [NS];
    logic [PM_W-1:0]     pm_nx_s    [NS];
    logic [PM_W:0]       min_new_s;
    logic [PM_W-1:0]     best_pm_s;

    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nx_s;
    logic [CNT_W-1:0] drain_cnt_r;

    logic take_s;
    logic start_s;
    logic emit_run_s;
    logic emit_drain_s;
    logic run_bit_s;
    logic drain_bit_s;

    logic ready_r;
    logic valid_r;
    logic bit_r;
    logic last_r;

    assign o_ready = ready_r;
    assign o_valid = valid_r;
    assign o_bit   = bit_r;
    assign o_last  = last_r;

    // Frame control: symbol acceptance, emit decisions and next FSM state.
    always_comb begin
        take_s       = i_valid && ready_r && ((state_r == ST_RUN) || i_first);
        start_s      = take_s && i_first;
        emit_run_s   = take_s && !i_first && (state_r == ST_RUN) && (cnt_r == CNT_FULL);
        emit_drain_s = (state_r == ST_DRAIN) && (drain_cnt_r != CNT_ZERO);
        state_nx_s   = state_r;
        case (state_r)
            ST_IDLE, ST_RUN: begin
                if (take_s) begin
                    if (i_last) begin
                        state_nx_s = ST_DRAIN;
                    end else begin
                        state_nx_s = ST_RUN;
                    end
                end else begin
                    state_nx_s = state_r;
                end
            end
            ST_DRAIN: begin
                if (drain_cnt_r <= CNT_ONE) begin
                    state_nx_s = ST_IDLE;
                end else begin
                    state_nx_s = ST_DRAIN;
                end
            end
            default: state_nx_s = ST_IDLE;
        endcase
    end

    // Symbols accepted in the current frame, saturating at the survivor depth.
    always_comb begin
        cnt_nx_s = cnt_r;
        if (start_s) begin
            cnt_nx_s = CNT_ONE;
        end else if (take_s && (cnt_r != CNT_FULL)) begin
            cnt_nx_s = cnt_r + CNT_ONE;
        end else begin
            cnt_nx_s = cnt_r;
        end
    end

    // ACS inputs: a frame start sees freshly initialised metrics and empty paths.
    always_comb begin
        for (int i = 0; i < NS; i++) begin
            if (start_s) begin
                pm_src_s[i]   = (i == 0) ? {PM_W{1'b0}} : PM_MAX;
                path_src_s[i] = {TB_DEPTH{1'b0}};
            end else begin
                pm_src_s[i]   = pm_r[i];
                path_src_s[i] = path_r[i];
            end
        end
    end

    for (genvar g = 0; g < NS; g++) begin : g_acs
        localparam int PA = (g * 2) % NS;
        viterbi_acs_cell #(
            .K        (K),
            .G0       (G0),
            .G1       (G1),
            .SOFT_W   (SOFT_W),
            .TB_DEPTH (TB_DEPTH),
            .PM_W     (PM_W),
            .STATE    (g)
        ) u_acs_cell (
            .rx0      (i_sym0),
            .rx1      (i_sym1),
            .pm_a     (pm_src_s[PA]),
            .pm_b     (pm_src_s[PA+1]),
            .path_a   (path_src_s[PA]),
            .path_b   (path_src_s[PA+1]),
            .pm_new   (acs_pm_s[g]),
            .path_new (acs_path_s[g])
        );
    end

    // Normalise new metrics by the minimum; clamp states still unreached.
    always_comb begin
        min_new_s = acs_pm_s[0];
        for (int i = 1; i < NS; i++) begin
            if (acs_pm_s[i] < min_new_s) begin
                min_new_s = acs_pm_s[i];
            end else begin
                min_new_s = min_new_s;
            end
        end
        for (int i = 0; i < NS; i++) begin
            norm_s[i] = acs_pm_s[i] - min_new_s;
            if (norm_s[i] > {1'b0, PM_MAX}) begin
                pm_nx_s[i] = PM_MAX;
            end else begin
                pm_nx_s[i] = norm_s[i][PM_W-1:0];
            end
        end
    end

    // Oldest survivor bit of the best state (lowest index wins ties).
    always_comb begin
        best_pm_s = pm_r[0];
        run_bit_s = path_r[0][TB_DEPTH-1];
        for (int i = 1; i < NS; i++) begin
            if (pm_r[i] < best_pm_s) begin
                best_pm_s = pm_r[i];
                run_bit_s = path_r[i][TB_DEPTH-1];
            end else begin
                best_pm_s = best_pm_s;
            end
        end
    end

    // Drain bit: state 0's survivor read from its oldest valid position down.
    always_comb begin
        drain_bit_s = 1'b0;
        for (int i = 0; i < TB_DEPTH; i++) begin
            if (CNT_W'(i) == (drain_cnt_r - CNT_ONE)) begin
                drain_bit_s = path_r[0][i];
            end else begin
                drain_bit_s = drain_bit_s;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Path metrics and survivors advance once per accepted symbol.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < NS; i++) begin
                pm_r[i]   <= (i == 0) ? {PM_W{1'b0}} : PM_MAX;
                path_r[i] <= {TB_DEPTH{1'b0}};
            end
        end else if (take_s) begin
            for (int i = 0; i < NS; i++) begin
                pm_r[i]   <= pm_nx_s[i];
                path_r[i] <= acs_path_s[i];
            end
        end
    end

    // Frame symbol count and remaining drain bits.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt_r       <= CNT_ZERO;
            drain_cnt_r <= CNT_ZERO;
        end else begin
            cnt_r <= cnt_nx_s;
            if (take_s && i_last) begin
                drain_cnt_r <= cnt_nx_s;
            end else if (emit_drain_s) begin
                drain_cnt_r <= drain_cnt_r - CNT_ONE;
            end
        end
    end

    // Registered handshake and decoded-bit outputs.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            ready_r <= 1'b1;
            valid_r <= 1'b0;
            bit_r   <= 1'b0;
            last_r  <= 1'b0;
        end else begin
            ready_r <= (state_nx_s != ST_DRAIN);
            valid_r <= emit_run_s || emit_drain_s;
            if (emit_run_s) begin
                bit_r <= run_bit_s;
            end else if (emit_drain_s) begin
                bit_r <= drain_bit_s;
            end else begin
                bit_r <= 1'b0;
            end
            last_r <= emit_drain_s && (drain_cnt_r == CNT_ONE);
        end
    end

endmodule

// File: tb/tb_viterbi_decoder_param.sv
// Directed bench for viterbi_decoder_param: hard-decision default instance
// plus a 3-bit soft-decision instance.
module tb_viterbi_decoder_param;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       v_h = 1'b0;
    logic       v_s = 1'b0;
    logic       first = 1'b0;
    logic       last = 1'b0;
    logic       sym0 = 1'b0;
    logic       sym1 = 1'b0;
    logic [2:0] ssym0 = 3'd0;
    logic [2:0] ssym1 = 3'd0;
    logic       rdy_h, ov_h, ob_h, ol_h;
    logic       rdy_s, ov_s, ob_s, ol_s;

    int checks = 0;
    int errors = 0;
    int acc_cnt = 0;
    int ready_low_h = 0;
    logic bits_h[$];
    logic last_h[$];
    int   acc_h[$];
    logic bits_s[$];
    logic last_s[$];
    logic [1:0] enc_sr;
    logic info [40];

    always #5 clk = ~clk;

    viterbi_decoder_param dut (
        .i_clk(clk), .i_rst(rst), .i_valid(v_h), .o_ready(rdy_h),
        .i_sym0(sym0), .i_sym1(sym1), .i_first(first), .i_last(last),
        .o_valid(ov_h), .o_bit(ob_h), .o_last(ol_h)
    );

    viterbi_decoder_param #(.SOFT_W(3)) dut_s (
        .i_clk(clk), .i_rst(rst), .i_valid(v_s), .o_ready(rdy_s),
        .i_sym0(ssym0), .i_sym1(ssym1), .i_first(first), .i_last(last),
        .o_valid(ov_s), .o_bit(ob_s), .o_last(ol_s)
    );

    // Output collector, sampled on the falling edge.
    always @(negedge clk) begin
        if (ov_h) begin
            bits_h.push_back(ob_h);
            last_h.push_back(ol_h);
            acc_h.push_back(acc_cnt);
        end
        if (!rdy_h) ready_low_h++;
        if (ov_s) begin
            bits_s.push_back(ob_s);
            last_s.push_back(ol_s);
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int qsize(input int sel);
        return (sel == 0) ? bits_h.size() : bits_s.size();
    endfunction

    function automatic int count_last(input int sel, input int base);
        int n = 0;
        for (int i = base; i < qsize(sel); i++)
            n += ((sel == 0) ? int'(last_h[i]) : int'(last_s[i]));
        return n;
    endfunction

    function automatic int last_pos(input int sel, input int base);
        for (int i = base; i < qsize(sel); i++)
            if (((sel == 0) ? last_h[i] : last_s[i]) == 1'b1) return i - base;
        return -1;
    endfunction

    function automatic logic [63:0] pack(input int sel, input int base, input int n);
        logic [63:0] v = 64'd0;
        for (int i = 0; i < n; i++) begin
            if (base + i < qsize(sel))
                v = {v[62:0], ((sel == 0) ? bits_h[base+i] : bits_s[base+i])};
            else
                v = {v[62:0], 1'b0};
        end
        return v;
    endfunction

    task automatic send_h(input logic b0, input logic b1, input logic f, input logic l);
        sym0 = b0; sym1 = b1; first = f; last = l; v_h = 1'b1;
        @(posedge clk); #1;
        v_h = 1'b0; first = 1'b0; last = 1'b0;
        acc_cnt++;
    endtask

    task automatic send_s(input logic [2:0] s0, input logic [2:0] s1, input logic f, input logic l);
        ssym0 = s0; ssym1 = s1; first = f; last = l; v_s = 1'b1;
        @(posedge clk); #1;
        v_s = 1'b0; first = 1'b0; last = 1'b0;
    endtask

    task automatic send_coded(input logic u, input logic f, input logic l);
        logic c0, c1;
        if (f) enc_sr = 2'b00;
        c0 = u ^ enc_sr[1] ^ enc_sr[0];
        c1 = u ^ enc_sr[0];
        send_h(c0, c1, f, l);
        enc_sr = {u, enc_sr[1]};
    endtask

    // Reference frame 11 10 00 01 01 11 (info 1 0 1 1 0 0); optional error on pair 2.
    task automatic send_frame36(input logic flip2);
        logic [1:0] pr [6];
        pr = '{2'b11, 2'b10, 2'b00, 2'b01, 2'b01, 2'b11};
        if (flip2) pr[1] = 2'b00;
        for (int i = 0; i < 6; i++) send_h(pr[i][1], pr[i][0], i == 0, i == 5);
    endtask

    task automatic wait_last(input int sel, input int base, input int budget);
        for (int c = 0; c < budget; c++) begin
            @(negedge clk); #1;
            if (count_last(sel, base) > 0) break;
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        int base;
        int rl0;
        logic [63:0] exp_v;
        logic [2:0] lv0, lv1;
        logic [1:0] pr;

        // Reset state
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("reset_valid", 64'(ov_h), 64'd0);
        check("reset_bit", 64'(ob_h), 64'd0);
        check("reset_last", 64'(ol_h), 64'd0);
        check("reset_ready", 64'(rdy_h), 64'd1);
        check("reset_ready_soft", 64'(rdy_s), 64'd1);

        // Symbol without i_first in IDLE is dropped
        base = bits_h.size();
        send_h(1'b1, 1'b1, 1'b0, 1'b1);
        repeat (25) @(posedge clk);
        #1 check("idle_discard", 64'(bits_h.size() - base), 64'd0);

        // Clean six-symbol frame
        base = bits_h.size();
        send_frame36(1'b0);
        wait_last(0, base, 60);
        check("f36_count", 64'(bits_h.size() - base), 64'd6);
        check("f36_bits", pack(0, base, 6), 64'b101100);
        check("f36_nlast", 64'(count_last(0, base)), 64'd1);
        check("f36_lastpos", 64'(last_pos(0, base)), 64'd5);

        // Same frame with one channel error
        base = bits_h.size();
        send_frame36(1'b1);
        wait_last(0, base, 60);
        check("f37_count", 64'(bits_h.size() - base), 64'd6);
        check("f37_bits", pack(0, base, 6), 64'b101100);
        check("f37_lastpos", 64'(last_pos(0, base)), 64'd5);

        // Single-symbol frame
        base = bits_h.size();
        send_h(1'b1, 1'b1, 1'b1, 1'b1);
        wait_last(0, base, 40);
        check("single_count", 64'(bits_h.size() - base), 64'd1);
        check("single_lastpos", 64'(last_pos(0, base)), 64'd0);
        check("single_bit", pack(0, base, 1), 64'd0);

        // 40-symbol random frame with zero tail
        for (int i = 0; i < 40; i++) info[i] = (i < 38) ? 1'($urandom_range(1, 0)) : 1'b0;
        base = bits_h.size();
        rl0 = ready_low_h;
        acc_cnt = 0;
        for (int i = 0; i < 40; i++) send_coded(info[i], i == 0, i == 39);
        wait_last(0, base, 100);
        exp_v = 64'd0;
        for (int i = 0; i < 40; i++) exp_v = {exp_v[62:0], info[i]};
        check("long_count", 64'(bits_h.size() - base), 64'd40);
        check("long_first_at", 64'((acc_h.size() > base) ? acc_h[base] : -1), 64'd16);
        check("long_bits", pack(0, base, 40), exp_v);
        check("long_drain_cycles", 64'(ready_low_h - rl0), 64'd15);
        check("long_nlast", 64'(count_last(0, base)), 64'd1);

        // New i_first at symbol 20 abandons the running frame
        base = bits_h.size();
        for (int i = 0; i < 19; i++) info[i] = 1'($urandom_range(1, 0));
        for (int i = 0; i < 19; i++) send_coded(info[i], i == 0, 1'b0);
        send_frame36(1'b0);
        wait_last(0, base, 60);
        exp_v = {54'd0, info[0], info[1], info[2], info[3], 6'b101100};
        check("restart_count", 64'(bits_h.size() - base), 64'd10);
        check("restart_bits", pack(0, base, 10), exp_v);
        check("restart_nlast", 64'(count_last(0, base)), 64'd1);
        check("restart_lastpos", 64'(last_pos(0, base)), 64'd9);

        // Reset pulse in the middle of a drain
        send_frame36(1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("drain_rst_ready", 64'(rdy_h), 64'd1);
        check("drain_rst_valid", 64'(ov_h), 64'd0);
        base = bits_h.size();
        repeat (20) @(posedge clk);
        #1 check("drain_rst_silent", 64'(bits_h.size() - base), 64'd0);
        base = bits_h.size();
        send_frame36(1'b1);
        wait_last(0, base, 60);
        check("after_rst_count", 64'(bits_h.size() - base), 64'd6);
        check("after_rst_bits", pack(0, base, 6), 64'b101100);

        // Soft decision, levels 0/7 with one ambiguous sample of 4
        base = bits_s.size();
        for (int i = 0; i < 6; i++) begin
            case (i)
                0: pr = 2'b11;
                1: pr = 2'b10;
                2: pr = 2'b00;
                3: pr = 2'b01;
                4: pr = 2'b01;
                default: pr = 2'b11;
            endcase
            lv0 = pr[1] ? 3'd7 : 3'd0;
            lv1 = pr[0] ? 3'd7 : 3'd0;
            if (i == 1) lv1 = 3'd4;
            send_s(lv0, lv1, i == 0, i == 5);
        end
        wait_last(1, base, 60);
        check("soft_count", 64'(bits_s.size() - base), 64'd6);
        check("soft_bits", pack(1, base, 6), 64'b101100);
        check("soft_lastpos", 64'(last_pos(1, base)), 64'd5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
